layer_scheduler: RTL and testbench
==================================

// Module: layer_scheduler
// PURPOSE
//  Top-level sequencer for the inference pipeline (conv -> fc1 -> fc2 ...).
//  Runs the layer blocks strictly in order and gives the active layer sole use of the
//  shared weight-ROM address port and the 128-lane MultAdder operand bus.
//  Replaces tri-state sharing with an explicit registered-select mux.
//  Raises done when the last layer finishes, error on a per-layer watchdog timeout.
// PARAMETERS
//  NUM_LAYERS  3     number of sequenced layer blocks (index 0 runs first)
//  bit         16    fixed-point word width; MultAdder operand = 128*bit
//  ADDR_W      11    weight-ROM address width
//  TIMEOUT     4096  max RUN cycles per layer before error
// PORTS
//  clk          in   1                    rising-edge clock
//  iRst         in   1                    synchronous, active-high reset
//  iStart       in   1                    start one inference (sampled in IDLE/FINISH/ERROR only)
//  iLayerDone   in   NUM_LAYERS           per-layer done level (held until its ena drops)
//  iLayerAddr   in   NUM_LAYERS*ADDR_W    per-layer ROM address, layer i at [i*ADDR_W +: ADDR_W]
//  iLayerOpr1   in   NUM_LAYERS*128*bit   per-layer MultAdder operand 1
//  iLayerOpr2   in   NUM_LAYERS*128*bit   per-layer MultAdder operand 2
//  oLayerEna    out  NUM_LAYERS           one-hot enable to layers (all 0 when none active)
//  oLayerRst_n  out  NUM_LAYERS           per-layer active-low reset, all bits 1 except as below
//  oAddrToRom   out  ADDR_W               muxed ROM address of active layer
//  oOpr1        out  128*bit              muxed operand 1 to MultAdder
//  oOpr2        out  128*bit              muxed operand 2 to MultAdder
//  oActive      out  $clog2(NUM_LAYERS)   index of current/last layer
//  oBusy        out  1                    1 in LRST/RUN/GAP
//  oDone        out  1                    level: inference complete, cleared by next iStart
//  oError       out  1                    level: watchdog fired, cleared by next iStart
// BEHAVIOUR
//  - Reset (iRst=1 at edge, overrides all): state IDLE, oLayerEna=0, oLayerRst_n=all 1,
//    oActive=0, oBusy=0, oDone=0, oError=0, watchdog=0. Mid-run reset drops ena same edge.
//  - FSM, registered; all outputs from registers except muxes:
//    IDLE:   iStart -> LRST, oActive=0, clear oDone/oError.
//    LRST:   1 cycle; oLayerEna[a]=1, oLayerRst_n[a]=0 -> RUN; watchdog=0.
//    RUN:    oLayerEna[a]=1, rst_n=1; watchdog++ each cycle.
//            iLayerDone[a]=1 -> GAP (a<NUM_LAYERS-1) or FINISH (a=last).
//            watchdog==TIMEOUT-1 and no done -> ERROR (done wins if same cycle).
//    GAP:    1 cycle, oLayerEna=0 (lets layer release done); oActive<=a+1 -> LRST.
//    FINISH: oLayerEna=0, oDone=1; iStart -> LRST with a=0, oDone cleared.
//    ERROR:  oLayerEna=0, oError=1; iStart -> LRST with a=0, oError cleared.
//  - iStart while busy ignored. iLayerDone bits of non-active layers ignored always.
//  - Latency: iStart at edge N -> ena[0]&!rst_n[0] after N+1, run after N+2;
//    done[a] seen at edge M -> ena[a+1] after M+2 (GAP,LRST), run after M+3.
//  - Mux: when any oLayerEna bit set, outputs = slice oActive; otherwise all zeros
//    (never z). Combinational from registered oActive/ena; no added latency.
//  - Watchdog width $clog2(TIMEOUT); no wrap (stops at terminal count).
// STRUCTURE
//  - Shared package/header: state encodings (IDLE,LRST,RUN,GAP,FINISH,ERROR),
//    bit=16, MAC_LANES=128, ROM_ADDR_W=11.
//  - One sub-module: layer_bus_mux (one-hot-gated slice select of addr/opr1/opr2).
//  - FSM, watchdog, oActive counter in this module.
// TESTING  (NUM_LAYERS=3, TIMEOUT=16 unless noted)
//  1 iStart pulse; layers assert done after 5,7,3 RUN cycles -> ena seq 001,010,100,
//    one-cycle rst_n low each, oDone=1 on cycle 2+5+2+7+2+3+1, oBusy low then.
//  2 Layer 1 addr=11'h401, opr1 lanes=16'h3C00; other layers drive 11'h7FF ->
//    oAddrToRom=11'h401, oOpr1 matches only while ena=010; 0 in GAP/IDLE.
//  3 Layer 1 never done -> oError=1 after 16 RUN cycles, ena=000; next iStart restarts at layer 0.
//  4 iRst=1 during layer 1 RUN -> next edge ena=000, all outputs reset, IDLE; iStart re-runs cleanly.
//  5 iStart pulsed during RUN, and iLayerDone[2]=1 while layer 0 active -> both ignored.
//  6 done and watchdog terminal on same cycle -> GAP taken, oError stays 0.

Source files
------------

// File: rtl/layer_scheduler_pkg.sv
// Shared constants and state encoding for the inference layer scheduler.
// Word and lane sizes match the 128-lane MultAdder and the weight-ROM address port.
package layer_scheduler_pkg;

  localparam int WORD_W     = 16;
  localparam int MAC_LANES  = 128;
  localparam int ROM_ADDR_W = 11;
  localparam int BUS_W      = MAC_LANES * WORD_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LRST,
    S_RUN,
    S_GAP,
    S_FINISH,
    S_ERROR
  } state_t;

endpackage

// File: rtl/layer_bus_mux.sv
// Selects the ROM address and MultAdder operands of the active layer.
// Drives all zeros whenever no layer is enabled, so the shared bus never floats.
module layer_bus_mux
  import layer_scheduler_pkg::*;
#(
  parameter int NUM_LAYERS = 3,
  parameter int ADDR_W     = ROM_ADDR_W,
  parameter int SEL_W      = 2
) (
  input  logic [SEL_W-1:0]            sel_i,
  input  logic                        en_i,
  input  logic [NUM_LAYERS*ADDR_W-1:0] addr_i,
  input  logic [NUM_LAYERS*BUS_W-1:0]  opr1_i,
  input  logic [NUM_LAYERS*BUS_W-1:0]  opr2_i,
  output logic [ADDR_W-1:0]           addr_o,
  output logic [BUS_W-1:0]            opr1_o,
  output logic [BUS_W-1:0]            opr2_o
);

  // NOTE: every output gets a default first so this block can never infer a latch.
  always_comb begin
    addr_o = '0;
    opr1_o = '0;
    opr2_o = '0;
    if (en_i) begin
      addr_o = addr_i[sel_i*ADDR_W +: ADDR_W];
      opr1_o = opr1_i[sel_i*BUS_W +: BUS_W];
      opr2_o = opr2_i[sel_i*BUS_W +: BUS_W];
    end
  end

endmodule

// File: rtl/layer_scheduler.sv
// Sequences the layer blocks in order, granting the active one the shared ROM/MAC bus.
// Raises oDone after the last layer finishes and oError when a layer overruns its watchdog.
module layer_scheduler
  import layer_scheduler_pkg::*;
#(
  parameter  int NUM_LAYERS = 3,
  parameter  int ADDR_W     = ROM_ADDR_W,
  parameter  int TIMEOUT    = 4096,
  localparam int ACT_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
  localparam int WD_W       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic                         clk,
  input  logic                         iRst,
  input  logic                         iStart,
  input  logic [NUM_LAYERS-1:0]        iLayerDone,
  input  logic [NUM_LAYERS*ADDR_W-1:0] iLayerAddr,
  input  logic [NUM_LAYERS*BUS_W-1:0]  iLayerOpr1,
  input  logic [NUM_LAYERS*BUS_W-1:0]  iLayerOpr2,
  output logic [NUM_LAYERS-1:0]        oLayerEna,
  output logic [NUM_LAYERS-1:0]        oLayerRst_n,
  output logic [ADDR_W-1:0]            oAddrToRom,
  output logic [BUS_W-1:0]             oOpr1,
  output logic [BUS_W-1:0]             oOpr2,
  output logic [ACT_W-1:0]             oActive,
  output logic                         oBusy,
  output logic                         oDone,
  output logic                         oError
);

  localparam logic [NUM_LAYERS-1:0] ENA_FIRST = NUM_LAYERS'(1);
  localparam logic [ACT_W-1:0]      LAST_IDX  = ACT_W'(NUM_LAYERS - 1);
  localparam logic [WD_W-1:0]       WD_LAST   = WD_W'(TIMEOUT - 1);

  state_t                  state_q;
  logic [NUM_LAYERS-1:0]   ena_q;
  logic [NUM_LAYERS-1:0]   rst_n_q;
  logic [ACT_W-1:0]        active_q;
  logic [WD_W-1:0]         wd_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    err_q;

  logic [ACT_W-1:0]        active_nxt;
  logic                    cur_done;
  logic                    any_ena;

  assign active_nxt = active_q + 1'b1;
  // Only the active layer's done bit is ever looked at; stray bits are ignored.
  assign cur_done   = iLayerDone[active_q];
  assign any_ena    = |ena_q;

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (iRst) begin
      state_q  <= S_IDLE;
      ena_q    <= '0;
      rst_n_q  <= '1;
      active_q <= '0;
      wd_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_FINISH, S_ERROR: begin
          if (iStart) begin
            state_q  <= S_LRST;
            active_q <= '0;
            ena_q    <= ENA_FIRST;
            rst_n_q  <= ~ENA_FIRST;
            wd_q     <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
          end
        end
        S_LRST: begin
          state_q <= S_RUN;
          rst_n_q <= '1;
        end
        S_RUN: begin
          // A done arriving on the terminal watchdog cycle still counts as success.
          if (cur_done) begin
            ena_q <= '0;
            if (active_q == LAST_IDX) begin
              state_q <= S_FINISH;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_GAP;
            end
          end else if (wd_q == WD_LAST) begin
            state_q <= S_ERROR;
            ena_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_GAP: begin
          state_q  <= S_LRST;
          active_q <= active_nxt;
          ena_q    <= ENA_FIRST << active_nxt;
          rst_n_q  <= ~(ENA_FIRST << active_nxt);
          wd_q     <= '0;
        end
        default: begin
          state_q <= S_IDLE;
          ena_q   <= '0;
          rst_n_q <= '1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign oLayerEna   = ena_q;
  assign oLayerRst_n = rst_n_q;
  assign oActive     = active_q;
  assign oBusy       = busy_q;
  assign oDone       = done_q;
  assign oError      = err_q;

  layer_bus_mux #(
    .NUM_LAYERS (NUM_LAYERS),
    .ADDR_W     (ADDR_W),
    .SEL_W      (ACT_W)
  ) u_bus_mux (
    .sel_i  (active_q),
    .en_i   (any_ena),
    .addr_i (iLayerAddr),
    .opr1_i (iLayerOpr1),
    .opr2_i (iLayerOpr2),
    .addr_o (oAddrToRom),
    .opr1_o (oOpr1),
    .opr2_o (oOpr2)
  );

endmodule

// File: tb/tb_layer_scheduler.sv
// Self-checking bench for layer_scheduler: randomized runs compared cycle by cycle
// against a timeline model built from per-layer run lengths.
module tb_layer_scheduler;
  import layer_scheduler_pkg::*;

  localparam int NL = 3;
  localparam int TO = 16;
  localparam int AW = ROM_ADDR_W;
  localparam int BW = BUS_W;
  localparam int ACTW = 2;

  logic                 clk = 1'b0;
  logic                 iRst = 1'b1;
  logic                 iStart = 1'b0;
  logic [NL-1:0]        iLayerDone = '0;
  logic [NL*AW-1:0]     iLayerAddr;
  logic [NL*BW-1:0]     iLayerOpr1;
  logic [NL*BW-1:0]     iLayerOpr2;
  logic [NL-1:0]        oLayerEna;
  logic [NL-1:0]        oLayerRst_n;
  logic [AW-1:0]        oAddrToRom;
  logic [BW-1:0]        oOpr1;
  logic [BW-1:0]        oOpr2;
  logic [ACTW-1:0]      oActive;
  logic                 oBusy;
  logic                 oDone;
  logic                 oError;

  logic [AW-1:0] addr_a [NL];
  logic [BW-1:0] opr1_a [NL];
  logic [BW-1:0] opr2_a [NL];

  always_comb begin
    iLayerAddr = '0;
    iLayerOpr1 = '0;
    iLayerOpr2 = '0;
    for (int i = 0; i < NL; i++) begin
      iLayerAddr[i*AW +: AW] = addr_a[i];
      iLayerOpr1[i*BW +: BW] = opr1_a[i];
      iLayerOpr2[i*BW +: BW] = opr2_a[i];
    end
  end

  always #5 clk = ~clk;

  layer_scheduler #(
    .NUM_LAYERS (NL),
    .TIMEOUT    (TO)
  ) dut (
    .clk         (clk),
    .iRst        (iRst),
    .iStart      (iStart),
    .iLayerDone  (iLayerDone),
    .iLayerAddr  (iLayerAddr),
    .iLayerOpr1  (iLayerOpr1),
    .iLayerOpr2  (iLayerOpr2),
    .oLayerEna   (oLayerEna),
    .oLayerRst_n (oLayerRst_n),
    .oAddrToRom  (oAddrToRom),
    .oOpr1       (oOpr1),
    .oOpr2       (oOpr2),
    .oActive     (oActive),
    .oBusy       (oBusy),
    .oDone       (oDone),
    .oError      (oError)
  );

  // One expected cycle of visible scheduler outputs; pulse marks the cycle the layer raises done.
  typedef struct {
    logic [NL-1:0] ena;
    logic [NL-1:0] rst_n;
    int            act;
    bit            busy;
    bit            done;
    bit            err;
    bit            pulse;
  } exp_t;

  exp_t plan[$];
  exp_t cur;
  bit   held;
  bit   rand_data;
  int   n_vec;
  int   n_err;

  function automatic exp_t mk(input logic [NL-1:0] ena, input logic [NL-1:0] rst_n,
                              input int act, input bit busy, input bit done,
                              input bit err, input bit pulse);
    exp_t r;
    r.ena = ena; r.rst_n = rst_n; r.act = act;
    r.busy = busy; r.done = done; r.err = err; r.pulse = pulse;
    return r;
  endfunction

  function automatic logic [63:0] fold(input logic [BW-1:0] v);
    logic [63:0] f;
    f = '0;
    for (int i = 0; i < BW/64; i++) f = {f[62:0], f[63]} ^ v[i*64 +: 64];
    return f;
  endfunction

  function automatic logic [BW-1:0] rand_bus();
    logic [BW-1:0] v;
    for (int i = 0; i < BW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Timeline of one inference: each layer gets LRST, then its run length (capped by the
  // watchdog), then GAP, FINISH or ERROR.
  task automatic plan_run(input int lens[NL]);
    plan.delete();
    for (int a = 0; a < NL; a++) begin
      int  run_len;
      bit  ok;
      logic [NL-1:0] oh;
      oh = NL'(1) << a;
      ok = (lens[a] >= 1) && (lens[a] <= TO);
      run_len = ok ? lens[a] : TO;
      plan.push_back(mk(oh, ~oh, a, 1'b1, 1'b0, 1'b0, 1'b0));
      for (int c = 1; c <= run_len; c++)
        plan.push_back(mk(oh, '1, a, 1'b1, 1'b0, 1'b0, ok && (c == run_len)));
      if (!ok) begin
        plan.push_back(mk('0, '1, a, 1'b0, 1'b0, 1'b1, 1'b0));
        return;
      end
      if (a < NL-1) plan.push_back(mk('0, '1, a, 1'b1, 1'b0, 1'b0, 1'b0));
      else          plan.push_back(mk('0, '1, a, 1'b0, 1'b1, 1'b0, 1'b0));
    end
  endtask

  task automatic cycle(input bit start, input bit rst);
    logic [NL-1:0] d;
    logic [AW-1:0] ea;
    logic [BW-1:0] e1;
    logic [BW-1:0] e2;
    bit            next_held;
    d = NL'($urandom);
    if (cur.busy) d[cur.act] = cur.pulse | held;
    iLayerDone = d;
    iStart = start | (cur.busy & ($urandom_range(0, 3) == 0));
    iRst   = rst;
    if (rand_data) for (int i = 0; i < NL; i++) addr_a[i] = AW'($urandom);
    next_held = cur.pulse & ~rst;
    @(posedge clk);
    #1;
    if (rst) begin
      cur = mk('0, '1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      plan.delete();
    end else if (plan.size() > 0) begin
      cur = plan.pop_front();
    end
    held   = next_held;
    iStart = 1'b0;
    iRst   = 1'b0;
    ea = '0; e1 = '0; e2 = '0;
    if (cur.ena != '0) begin
      ea = addr_a[cur.act];
      e1 = opr1_a[cur.act];
      e2 = opr2_a[cur.act];
    end
    check("ena",   64'(oLayerEna),   64'(cur.ena));
    check("rst_n", 64'(oLayerRst_n), 64'(cur.rst_n));
    check("active", 64'(oActive),    64'(cur.act));
    check("busy",  64'(oBusy),       64'(cur.busy));
    check("done",  64'(oDone),       64'(cur.done));
    check("error", 64'(oError),      64'(cur.err));
    check("addr",  64'(oAddrToRom),  64'(ea));
    check("opr1",  fold(oOpr1),      fold(e1));
    check("opr2",  fold(oOpr2),      fold(e2));
  endtask

  // rst_at: cycle index (0 = the start edge) whose closing edge carries iRst; -1 for none.
  task automatic run_inf(input int lens[NL], input int rst_at);
    int k;
    plan_run(lens);
    cycle(1'b1, rst_at == 0);
    k = 1;
    while (plan.size() > 0) begin
      cycle(1'b0, k == rst_at);
      k++;
    end
    repeat (2 + $urandom_range(0, 2)) cycle(1'b0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    held  = 1'b0;
    cur   = mk('0, '1, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Directed data: layer 1 addr 401 with 3C00 lanes, the others all-ones.
    rand_data = 1'b0;
    for (int i = 0; i < NL; i++) begin
      addr_a[i] = '1;
      opr1_a[i] = '1;
      opr2_a[i] = rand_bus();
    end
    addr_a[1] = 11'h401;
    for (int l = 0; l < MAC_LANES; l++) opr1_a[1][l*WORD_W +: WORD_W] = 16'h3C00;

    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    repeat (2) cycle(1'b0, 1'b0);

    run_inf('{5, 7, 3}, -1);
    run_inf('{4, 0, 3}, -1);
    run_inf('{2, 2, 2}, -1);
    run_inf('{3, 6, 4}, 8);
    run_inf('{1, 1, 1}, -1);
    run_inf('{2, TO, 1}, -1);
    run_inf('{TO, TO, TO}, -1);
    run_inf('{1, TO + 1, 2}, -1);

    rand_data = 1'b1;
    for (int r = 0; r < 24; r++) begin
      int lens[NL];
      int rst_at;
      for (int i = 0; i < NL; i++) begin
        if ($urandom_range(0, 9) == 0) lens[i] = ($urandom_range(0, 1) == 1) ? 0 : TO + 3;
        else                           lens[i] = $urandom_range(1, TO);
        opr1_a[i] = rand_bus();
        opr2_a[i] = rand_bus();
      end
      rst_at = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 30) : -1;
      run_inf(lens, rst_at);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
